matrix_inv_sched: RTL and testbench

Round-robin job scheduler for the shared Cholesky matrix-inversion core (cholesky -> lower inverse -> transpose -> multiply pipeline).
- Arbitrates between NUM_REQ requesters and issues one in_valid pulse per job.
- Tracks the single outstanding job until the core's out_valid, and reports completion with requester id and measured latency.
- A watchdog aborts jobs the core never completes.

---
 rtl/matrix_inv_sched.sv | 169 ++++++++++++++++
 tb/tb_matrix_inv_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_inv_sched.sv
// -----------------------------------------------------------------------------
// matrix_inv_sched
//   Round-robin job scheduler for the shared Cholesky matrix-inversion core.
//   Picks one of NUM_REQ requesters, issues a single in_valid pulse to the
//   core, waits for the core's out_valid (or a watchdog timeout), then reports
//   completion with the owner id and the measured issue-to-completion latency.
//   Only one job is ever in flight.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req            per-requester level request, held until granted
//   grant          one-hot, one-cycle grant pulse (coincident with core_in_valid)
//   core_in_valid  one-cycle start pulse to the core
//   core_out_valid core completion pulse (only honoured while waiting)
//   done           one-cycle completion pulse
//   done_id        requester id of the completed job (held between pulses)
//   done_err       job was aborted by the watchdog (held between pulses)
//   lat_cycles     issue-to-completion cycles (held between pulses)
//   busy           a job is in flight
//   timeout_err    sticky watchdog flag, cleared by clear_err (set wins)
//   clear_err      clears timeout_err
//   jobs_done      count of successful jobs
//
// Configuration
//   MATRIX_INV_SCHED_STATS_EN : when defined, jobs_done counts successful
//   completions (wrapping). When undefined, jobs_done is tied to zero.
// -----------------------------------------------------------------------------
module matrix_inv_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               core_in_valid,
  input  logic               core_out_valid,
  output logic               done,
  output logic [ID_W-1:0]    done_id,
  output logic               done_err,
  output logic [CNT_W-1:0]   lat_cycles,
  output logic               busy,
  output logic               timeout_err,
  input  logic               clear_err,
  output logic [CNT_W-1:0]   jobs_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   owner_q;
  logic [ID_W-1:0]   pick;
  logic              found;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Watchdog fires on the last allowed cycle unless the core answers in that
  // same cycle; a simultaneous out_valid counts as success.
  assign timeout_hit = (state_q == WAIT) && !core_out_valid &&
                       (cnt_inc == CNT_W'(TIMEOUT));

  // Round-robin pick: first set request bit strictly after the last owner.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_d       = state_q;
    grant         = '0;
    core_in_valid = 1'b0;
    done          = 1'b0;
    busy          = (state_q != IDLE);
    case (state_q)
      IDLE:  if (found) state_d = ISSUE;
      ISSUE: begin
        grant         = NUM_REQ'(1) << owner_q;
        core_in_valid = 1'b1;
        state_d       = WAIT;
      end
      WAIT:  if (core_out_valid || timeout_hit) state_d = RESP;
      RESP: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= ID_W'(NUM_REQ - 1);
      owner_q    <= '0;
      cnt_q      <= '0;
      done_id    <= '0;
      done_err   <= 1'b0;
      lat_cycles <= '0;
    end else begin
      case (state_q)
        IDLE:  if (found) owner_q <= pick;
        ISSUE: begin
          ptr_q <= owner_q;
          cnt_q <= '0;
        end
        WAIT: begin
          if (cnt_q != CNT_W'(TIMEOUT)) cnt_q <= cnt_inc;
          if (core_out_valid) begin
            lat_cycles <= cnt_inc;
            done_err   <= 1'b0;
            done_id    <= owner_q;
          end else if (timeout_hit) begin
            lat_cycles <= CNT_W'(TIMEOUT);
            done_err   <= 1'b1;
            done_id    <= owner_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           timeout_err <= 1'b0;
    else if (timeout_hit) timeout_err <= 1'b1;
    else if (clear_err)   timeout_err <= 1'b0;
  end

`ifdef MATRIX_INV_SCHED_STATS_EN
  logic [CNT_W-1:0] jobs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             jobs_q <= '0;
    else if ((state_q == RESP) && !done_err) jobs_q <= jobs_q + CNT_W'(1);
  end

  assign jobs_done = jobs_q;
`else
  assign jobs_done = '0;
`endif

endmodule

// File: tb/tb_matrix_inv_sched.sv
// -----------------------------------------------------------------------------
// tb_matrix_inv_sched
//   Directed self-checking bench for matrix_inv_sched (NUM_REQ=4, TIMEOUT=1024).
//   Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_matrix_inv_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1024;
`ifdef MATRIX_INV_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               core_in_valid;
  logic               core_out_valid;
  logic               done;
  logic [ID_W-1:0]    done_id;
  logic               done_err;
  logic [CNT_W-1:0]   lat_cycles;
  logic               busy;
  logic               timeout_err;
  logic               clear_err;
  logic [CNT_W-1:0]   jobs_done;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_inv_sched #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
    .core_in_valid(core_in_valid), .core_out_valid(core_out_valid),
    .done(done), .done_id(done_id), .done_err(done_err),
    .lat_cycles(lat_cycles), .busy(busy), .timeout_err(timeout_err),
    .clear_err(clear_err), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the issue cycle and check grant and its latency.
  task automatic wait_grant(input string tag, input logic [3:0] exp_grant,
                            input int exp_wait, input bit drop_req);
    int n = 0;
    while (!core_in_valid && n < 8) begin
      step();
      n++;
    end
    check({tag, "_issued"}, 32'(core_in_valid), 32'd1);
    check({tag, "_grant"},  32'(grant), 32'(exp_grant));
    check({tag, "_wait"},   n, exp_wait);
    if (drop_req) req = '0;
  endtask

  // Called in the issue cycle; core answers 'lat' cycles later.
  task automatic finish_job(input string tag, input int lat, input int id);
    repeat (lat) step();
    check({tag, "_no_early_done"}, 32'(done), 32'd0);
    core_out_valid = 1'b1;
    step();
    core_out_valid = 1'b0;
    check({tag, "_done"},     32'(done), 32'd1);
    check({tag, "_done_id"},  32'(done_id), id);
    check({tag, "_done_err"}, 32'(done_err), 32'd0);
    check({tag, "_lat"},      32'(lat_cycles), lat);
  endtask

  // Called in the issue cycle; core never answers.
  task automatic run_timeout(input string tag, input int id, input bit clr_same);
    repeat (TIMEOUT) step();
    check({tag, "_no_early_done"}, 32'(done), 32'd0);
    clear_err = clr_same;
    step();
    clear_err = 1'b0;
    check({tag, "_done"},     32'(done), 32'd1);
    check({tag, "_done_id"},  32'(done_id), id);
    check({tag, "_done_err"}, 32'(done_err), 32'd1);
    check({tag, "_lat"},      32'(lat_cycles), TIMEOUT);
    check({tag, "_terr"},     32'(timeout_err), 32'd1);
  endtask

  initial begin
    bit saw_done;
    rst_n          = 1'b0;
    req            = '0;
    core_out_valid = 1'b0;
    clear_err      = 1'b0;
    #12;
    check("rst_grant",  32'(grant), 32'd0);
    check("rst_inv",    32'(core_in_valid), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_id",     32'(done_id), 32'd0);
    check("rst_err",    32'(done_err), 32'd0);
    check("rst_lat",    32'(lat_cycles), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_terr",   32'(timeout_err), 32'd0);
    check("rst_jobs",   32'(jobs_done), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();

    // Round-robin with all requesters active: 0,1,2,3,0.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr", 4'(1) << (k % 4), 1, k == 4);
      finish_job("rr", 5, k % 4);
      if (k < 4) begin
        step();
        check("rr_busy_gap", 32'(busy), 32'd0);
      end
    end
    step();
    step();

    // Single request, latency 20.
    req = 4'b0100;
    wait_grant("single", 4'b0100, 1, 1'b1);
    finish_job("single", 20, 2);
    step();
    check("single_done_pulse", 32'(done), 32'd0);
    check("single_lat_hold",   32'(lat_cycles), 32'd20);
    check("single_id_hold",    32'(done_id), 32'd2);
    check("single_busy_off",   32'(busy), 32'd0);
    check("jobs_after_six",    32'(jobs_done), STATS ? 32'd6 : 32'd0);
    step();

    // Timeout on requester 0, then clear.
    req = 4'b0001;
    wait_grant("to1", 4'b0001, 1, 1'b1);
    run_timeout("to1", 0, 1'b0);
    step();
    check("to1_terr_sticky", 32'(timeout_err), 32'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("to1_terr_cleared", 32'(timeout_err), 32'd0);

    // Second timeout with clear_err on the same cycle: set wins.
    req = 4'b1000;
    wait_grant("to2", 4'b1000, 1, 1'b1);
    run_timeout("to2", 3, 1'b1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("to2_terr_cleared", 32'(timeout_err), 32'd0);

    // Race: out_valid on the final timeout cycle counts as success.
    req = 4'b0010;
    wait_grant("race", 4'b0010, 1, 1'b1);
    finish_job("race", TIMEOUT, 1);
    check("race_terr", 32'(timeout_err), 32'd0);
    check("jobs_after_race", 32'(jobs_done), STATS ? 32'd7 : 32'd0);

    // Spurious out_valid while idle.
    step();
    core_out_valid = 1'b1;
    step();
    core_out_valid = 1'b0;
    check("spur_done", 32'(done), 32'd0);
    check("spur_busy", 32'(busy), 32'd0);
    step();
    check("spur_done2", 32'(done), 32'd0);
    check("spur_busy2", 32'(busy), 32'd0);
    check("spur_id_hold", 32'(done_id), 32'd1);

    // Reset in the middle of a job.
    req = 4'b0100;
    wait_grant("mid", 4'b0100, 1, 1'b1);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_id",   32'(done_id), 32'd0);
    check("mid_lat",  32'(lat_cycles), 32'd0);
    check("mid_err",  32'(done_err), 32'd0);
    check("mid_jobs", 32'(jobs_done), 32'd0);
    step();
    rst_n = 1'b1;
    saw_done = 1'b0;
    core_out_valid = 1'b1;
    step();
    core_out_valid = 1'b0;
    saw_done = saw_done | done;
    repeat (30) begin
      step();
      saw_done = saw_done | done;
    end
    check("mid_no_done", 32'(saw_done), 32'd0);

    // After reset req[0] leads the search, so 1010 grants requester 1.
    req = 4'b1010;
    wait_grant("post1", 4'b0010, 1, 1'b1);
    finish_job("post1", 3, 1);
    step();
    step();
    req = 4'b1000;
    wait_grant("post2", 4'b1000, 1, 1'b1);
    finish_job("post2", 7, 3);
    step();
    step();
    req = 4'b0001;
    wait_grant("post3", 4'b0001, 1, 1'b1);
    finish_job("post3", 1, 0);
    step();
    step();
    req = 4'b0100;
    wait_grant("post_to", 4'b0100, 1, 1'b1);
    run_timeout("post_to", 2, 1'b0);
    step();
    check("jobs_final", 32'(jobs_done), STATS ? 32'd3 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
